// File: rtl/fir_decim_pkg.sv
// fir_decim_pkg: shared FSM encoding, Q15 low-pass coefficient table and trailer bit positions.
package fir_decim_pkg;

   typedef enum logic [3:0] {
      IDLE    = 4'b0001,
      HEADER  = 4'b0010,
      DATA    = 4'b0100,
      TRAILER = 4'b1000
   } state_t;

   localparam int FIR_COEF_W = 16;
   localparam int SHORT_BIT  = 0;
   localparam int SAT_BIT    = 1;

   // Half-band style low-pass, DC gain 33916/32768 (just above unity); taps past 20 are zero.
   localparam logic signed [FIR_COEF_W-1:0] FIR_COEFS [0:63] = '{
      16'sd0, 16'sd1159, 16'sd0, -16'sd1490, 16'sd0, 16'sd2086, 16'sd0, -16'sd3477,
      16'sd0, 16'sd10430, 16'sd16500, 16'sd10430, 16'sd0, -16'sd3477, 16'sd0, 16'sd2086,
      16'sd0, -16'sd1490, 16'sd0, 16'sd1159, 16'sd0, 16'sd0, 16'sd0, 16'sd0,
      16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0,
      16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0,
      16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0,
      16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0,
      16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0
   };

endpackage

// File: rtl/fir_mac_comb.sv
// fir_mac_comb: sample history plus a combinational MAC over {new sample, history}, scaled back to DATA_WIDTH.
// With FIR_DECIM_SAT_EN defined out-of-range results clamp; otherwise the low DATA_WIDTH bits wrap.
module fir_mac_comb
   import fir_decim_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int COEF_WIDTH = 16,
   parameter int NUM_TAPS   = 21
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         shift_en,
   input  logic                         clear,
   input  logic signed [DATA_WIDTH-1:0] sample,
   output logic signed [DATA_WIDTH-1:0] result,
   output logic                         overflow
);

   localparam int ACC_W = DATA_WIDTH + COEF_WIDTH + $clog2(NUM_TAPS);
   localparam int HIST  = (NUM_TAPS > 1) ? NUM_TAPS - 1 : 1;

   logic signed [DATA_WIDTH-1:0] hist [HIST];
   logic signed [DATA_WIDTH-1:0] tap  [NUM_TAPS];
   logic signed [ACC_W-1:0]      acc;
   logic signed [ACC_W-1:0]      shifted;
   logic [ACC_W-DATA_WIDTH:0]    upper;

   // The sample being accepted is tap 0, so the history only needs NUM_TAPS-1 entries.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < HIST; k++) hist[k] <= '0;
      end else if (clear) begin
         for (int k = 0; k < HIST; k++) hist[k] <= '0;
      end else if (shift_en) begin
         hist[0] <= sample;
         for (int k = 1; k < HIST; k++) hist[k] <= hist[k-1];
      end
   end

   always_comb begin
      tap[0] = sample;
      for (int k = 1; k < NUM_TAPS; k++) tap[k] = hist[k-1];
      acc = '0;
      for (int k = 0; k < NUM_TAPS; k++) begin
         acc = acc + ACC_W'(tap[k]) * ACC_W'(FIR_COEFS[k]);
      end
      shifted  = acc >>> (COEF_WIDTH - 1);
      upper    = shifted[ACC_W-1:DATA_WIDTH-1];
      overflow = !((&upper) || !(|upper));
`ifdef FIR_DECIM_SAT_EN
      if (overflow) begin
         result = shifted[ACC_W-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                   : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else begin
         result = shifted[DATA_WIDTH-1:0];
      end
`else
      result = shifted[DATA_WIDTH-1:0];
`endif
   end

endmodule

// File: rtl/fir_decim_st.sv
// fir_decim_st: packet-aware Avalon-ST FIR decimator; header forwarded, data filtered/decimated, status trailer appended.
// Define FIR_DECIM_SAT_EN to clamp out-of-range results and report them in trailer bit 1.
module fir_decim_st
   import fir_decim_pkg::*;
#(
   parameter int DATA_WIDTH   = 16,
   parameter int COEF_WIDTH   = 16,
   parameter int NUM_TAPS     = 21,
   parameter int FACTOR       = 2,
   parameter int HEADER_WORDS = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic                  data_input_ready,
   input  logic                  data_input_valid,
   input  logic                  data_input_startofpacket,
   input  logic                  data_input_endofpacket,
   input  logic [DATA_WIDTH-1:0] data_input_data,
   input  logic                  data_output_ready,
   output logic                  data_output_valid,
   output logic                  data_output_startofpacket,
   output logic                  data_output_endofpacket,
   output logic [DATA_WIDTH-1:0] data_output_data
);

`ifdef FIR_DECIM_SAT_EN
   localparam logic SAT_EN = 1'b1;
`else
   localparam logic SAT_EN = 1'b0;
`endif

   state_t                       state, state_next;
   logic [3:0]                   hdr_cnt;
   logic [3:0]                   phase;
   logic [6:0]                   samp_cnt;
   logic                         sat_flag;
   logic [DATA_WIDTH-1:0]        status;
   logic                         in_beat, out_free;
   logic                         out_load, out_sop_next, out_eop_next;
   logic [DATA_WIDTH-1:0]        out_data_next, trailer_word;
   logic                         hdr_start, hdr_inc, shift_en, status_load, trailer_fire;
   logic signed [DATA_WIDTH-1:0] mac_result;
   logic                         mac_overflow;

   assign out_free         = !data_output_valid || data_output_ready;
   assign data_input_ready = out_free && (state != TRAILER);
   assign in_beat          = data_input_valid && data_input_ready;

   fir_mac_comb #(
      .DATA_WIDTH(DATA_WIDTH),
      .COEF_WIDTH(COEF_WIDTH),
      .NUM_TAPS  (NUM_TAPS)
   ) u_mac (
      .clk     (clk),
      .reset   (reset),
      .shift_en(shift_en),
      .clear   (trailer_fire),
      .sample  (data_input_data),
      .result  (mac_result),
      .overflow(mac_overflow)
   );

   // A header cut short by eop leaves samp_cnt at 0, so the short bit covers that case too.
   always_comb begin
      trailer_word            = status;
      trailer_word[SAT_BIT]   = sat_flag & SAT_EN;
      trailer_word[SHORT_BIT] = samp_cnt < 7'(NUM_TAPS);
   end

   always_comb begin
      state_next    = state;
      out_load      = 1'b0;
      out_sop_next  = 1'b0;
      out_eop_next  = 1'b0;
      out_data_next = data_input_data;
      hdr_start     = 1'b0;
      hdr_inc       = 1'b0;
      shift_en      = 1'b0;
      status_load   = 1'b0;
      trailer_fire  = 1'b0;
      case (state)
         IDLE: begin
            if (in_beat && data_input_startofpacket) begin
               out_load     = 1'b1;
               out_sop_next = 1'b1;
               hdr_start    = 1'b1;
               state_next   = (HEADER_WORDS == 1) ? DATA : HEADER;
            end
         end
         HEADER: begin
            if (in_beat) begin
               if (data_input_endofpacket) begin
                  status_load = 1'b1;
                  state_next  = TRAILER;
               end else begin
                  out_load = 1'b1;
                  hdr_inc  = 1'b1;
                  if (hdr_cnt + 4'd1 == 4'(HEADER_WORDS)) state_next = DATA;
               end
            end
         end
         DATA: begin
            if (in_beat) begin
               if (data_input_endofpacket) begin
                  status_load = 1'b1;
                  state_next  = TRAILER;
               end else begin
                  shift_en = 1'b1;
                  if (phase == 4'(FACTOR - 1)) begin
                     out_load      = 1'b1;
                     out_data_next = mac_result;
                  end
               end
            end
         end
         TRAILER: begin
            if (out_free) begin
               out_load      = 1'b1;
               out_eop_next  = 1'b1;
               out_data_next = trailer_word;
               trailer_fire  = 1'b1;
               state_next    = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // samp_cnt saturates at NUM_TAPS since it only feeds the short-packet test.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hdr_cnt  <= '0;
         phase    <= '0;
         samp_cnt <= '0;
         sat_flag <= 1'b0;
         status   <= '0;
      end else begin
         if (hdr_start)    hdr_cnt <= 4'd1;
         else if (hdr_inc) hdr_cnt <= hdr_cnt + 4'd1;
         if (status_load)  status  <= data_input_data;
         if (trailer_fire) begin
            phase    <= '0;
            samp_cnt <= '0;
            sat_flag <= 1'b0;
         end else if (shift_en) begin
            phase <= (phase == 4'(FACTOR - 1)) ? '0 : phase + 4'd1;
            if (samp_cnt < 7'(NUM_TAPS)) samp_cnt <= samp_cnt + 7'd1;
            if (phase == 4'(FACTOR - 1) && mac_overflow) sat_flag <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_output_valid         <= 1'b0;
         data_output_startofpacket <= 1'b0;
         data_output_endofpacket   <= 1'b0;
         data_output_data          <= '0;
      end else if (out_load) begin
         data_output_valid         <= 1'b1;
         data_output_startofpacket <= out_sop_next;
         data_output_endofpacket   <= out_eop_next;
         data_output_data          <= out_data_next;
      end else if (data_output_ready) begin
         data_output_valid         <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fir_decim_st.sv
// tb_fir_decim_st: directed packets through a default instance and a FACTOR=1 instance.
`timescale 1ns/1ps
module tb_fir_decim_st;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sel = 1'b0;
   logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
   logic [15:0] in_data = '0;
   logic        out_ready = 1'b1;

   logic        ready_a, valid_a, sop_a, eop_a;
   logic [15:0] data_a;
   logic        ready_b, valid_b, sop_b, eop_b;
   logic [15:0] data_b;
   logic        i_ready, o_valid, o_sop, o_eop;
   logic [15:0] o_data;

   int          ready_mode = 0, ready_phase = 0;
   int          checks = 0, passed = 0;
   int          stall_cycles = 0, ready_viol = 0, stable_viol = 0;
   logic        prev_stall = 1'b0;
   logic [17:0] prev_out = '0;
   logic [17:0] stim_q[$], exp_q[$], obs_q[$];
   int          xs[$];
   int          coef [21] = '{0, 1159, 0, -1490, 0, 2086, 0, -3477, 0, 10430, 16500,
                              10430, 0, -3477, 0, 2086, 0, -1490, 0, 1159, 0};

   always #5 clk = ~clk;

   assign i_ready = sel ? ready_b : ready_a;
   assign o_valid = sel ? valid_b : valid_a;
   assign o_sop   = sel ? sop_b   : sop_a;
   assign o_eop   = sel ? eop_b   : eop_a;
   assign o_data  = sel ? data_b  : data_a;

   fir_decim_st dut (
      .clk(clk), .reset(reset),
      .data_input_ready(ready_a), .data_input_valid(in_valid & ~sel),
      .data_input_startofpacket(in_sop), .data_input_endofpacket(in_eop), .data_input_data(in_data),
      .data_output_ready(out_ready | sel), .data_output_valid(valid_a),
      .data_output_startofpacket(sop_a), .data_output_endofpacket(eop_a), .data_output_data(data_a)
   );

   fir_decim_st #(.FACTOR(1)) dut_f1 (
      .clk(clk), .reset(reset),
      .data_input_ready(ready_b), .data_input_valid(in_valid & sel),
      .data_input_startofpacket(in_sop), .data_input_endofpacket(in_eop), .data_input_data(in_data),
      .data_output_ready(out_ready | ~sel), .data_output_valid(valid_b),
      .data_output_startofpacket(sop_b), .data_output_endofpacket(eop_b), .data_output_data(data_b)
   );

   // Sink ready pattern 1,0,0,1 in stall mode, changed just after each rising edge.
   always @(posedge clk) begin
      #1;
      if (ready_mode == 1) begin
         out_ready   = (ready_phase == 0) || (ready_phase == 3);
         ready_phase = (ready_phase + 1) % 4;
      end else begin
         out_ready = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (!reset && o_valid && out_ready) obs_q.push_back({o_sop, o_eop, o_data});
      if (!reset && ready_mode == 1) begin
         if (o_valid && !out_ready) begin
            stall_cycles++;
            if (i_ready) ready_viol++;
         end
         if (prev_stall && ({o_sop, o_eop, o_data} != prev_out || !o_valid)) stable_viol++;
         prev_stall = o_valid && !out_ready;
         prev_out   = {o_sop, o_eop, o_data};
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) passed++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
   endtask

   function automatic logic [17:0] beat(input logic sop, input logic eop, input logic [15:0] d);
      return {sop, eop, d};
   endfunction

   function automatic logic [15:0] model_y(input int n, output bit ovf);
      longint acc = 0;
      for (int k = 0; k < 21; k++) if (n - k >= 0) acc += longint'(xs[n-k]) * coef[k];
      acc = acc >>> 15;
      ovf = (acc > 32767) || (acc < -32768);
`ifdef FIR_DECIM_SAT_EN
      if (acc > 32767) acc = 32767;
      else if (acc < -32768) acc = -32768;
`endif
      return acc[15:0];
   endfunction

   task automatic add_header();
      stim_q.push_back(beat(1'b1, 1'b0, 16'h1111)); exp_q.push_back(beat(1'b1, 1'b0, 16'h1111));
      stim_q.push_back(beat(1'b0, 1'b0, 16'h2222)); exp_q.push_back(beat(1'b0, 1'b0, 16'h2222));
      stim_q.push_back(beat(1'b0, 1'b0, 16'h3333)); exp_q.push_back(beat(1'b0, 1'b0, 16'h3333));
   endtask

   task automatic build_data(input int factor, output bit any_ovf);
      bit ovf;
      any_ovf = 1'b0;
      foreach (xs[n]) begin
         stim_q.push_back(beat(1'b0, 1'b0, 16'(xs[n])));
         if (n % factor == factor - 1) begin
            exp_q.push_back(beat(1'b0, 1'b0, model_y(n, ovf)));
            any_ovf |= ovf;
         end
      end
   endtask

   // Impulse response at the odd sample positions: y[m] = (0x7FFF * c[2m+1]) >>> 15.
   task automatic build_impulse();
      int cv, y;
      stim_q.delete(); exp_q.delete();
      add_header();
      stim_q.push_back(beat(1'b0, 1'b0, 16'h7FFF));
      repeat (23) stim_q.push_back(beat(1'b0, 1'b0, 16'h0000));
      for (int m = 0; m < 12; m++) begin
         cv = (2*m + 1 < 21) ? coef[2*m + 1] : 0;
         y  = (32767 * cv) >>> 15;
         exp_q.push_back(beat(1'b0, 1'b0, 16'(y)));
      end
      stim_q.push_back(beat(1'b0, 1'b1, 16'hABCC));
      exp_q.push_back(beat(1'b0, 1'b1, 16'hABCC));
   endtask

   task automatic send_beat(input logic [17:0] b, output bit ok);
      int waits = 0;
      ok = 1'b1;
      @(negedge clk);
      {in_sop, in_eop, in_data} = b;
      in_valid = 1'b1;
      while (!i_ready) begin
         @(negedge clk);
         waits++;
         if (waits > 500) begin
            ok = 1'b0;
            in_valid = 1'b0;
            return;
         end
      end
      @(posedge clk);
   endtask

   task automatic applyStimulus(input string name);
      bit          ok;
      int          sent = 0, waits = 0;
      logic [17:0] act;
      obs_q.delete();
      foreach (stim_q[i]) begin
         send_beat(stim_q[i], ok);
         if (!ok) break;
         sent++;
      end
      @(negedge clk);
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
      while (obs_q.size() < exp_q.size() && waits < 2000) begin
         @(negedge clk);
         waits++;
      end
      repeat (4) @(negedge clk);
      checkOutput({name, "_accepted"}, sent, stim_q.size());
      checkOutput({name, "_count"}, obs_q.size(), exp_q.size());
      foreach (exp_q[i]) begin
         act = (i < obs_q.size()) ? obs_q[i] : 18'h3FFFF;
         checkOutput($sformatf("%s_beat%0d", name, i), act, exp_q[i]);
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
   endtask

   initial begin
      bit          any_ovf, ok;
      logic        sat_bit;
      logic [17:0] last;

      repeat (2) @(negedge clk);
      checkOutput("reset_outputs", {o_valid, o_sop, o_eop, o_data}, 19'h0);
      checkOutput("reset_ready", i_ready, 1);
      reset = 1'b0;

      build_impulse();
      applyStimulus("impulse");

      stall_cycles = 0; ready_viol = 0; stable_viol = 0; prev_stall = 1'b0;
      ready_mode = 1;
      applyStimulus("stall");
      ready_mode = 0;
      repeat (2) @(negedge clk);
      checkOutput("stall_seen", stall_cycles > 0, 1);
      checkOutput("stall_ready_low", ready_viol, 0);
      checkOutput("stall_stable", stable_viol, 0);

      pulse_reset();
      sel = 1'b1;
      xs.delete();
      repeat (30) xs.push_back(32'h1000);
      stim_q.delete(); exp_q.delete();
      add_header();
      build_data(1, any_ovf);
      stim_q.push_back(beat(1'b0, 1'b1, 16'h5550));
      exp_q.push_back(beat(1'b0, 1'b1, 16'h5550));
      applyStimulus("dc_f1");
      last = (obs_q.size() > 32) ? obs_q[32] : 18'h3FFFF;
      checkOutput("dc_f1_final", last, {2'b00, 16'd4239});

      pulse_reset();
      sel = 1'b0;
      stim_q.delete(); exp_q.delete();
      stim_q.push_back(beat(1'b1, 1'b0, 16'h1111)); exp_q.push_back(beat(1'b1, 1'b0, 16'h1111));
      stim_q.push_back(beat(1'b0, 1'b1, 16'h0004)); exp_q.push_back(beat(1'b0, 1'b1, 16'h0005));
      applyStimulus("short");

      xs.delete();
      repeat (22) xs.push_back(32767);
      repeat (22) xs.push_back(-32767);
      stim_q.delete(); exp_q.delete();
      add_header();
      build_data(2, any_ovf);
`ifdef FIR_DECIM_SAT_EN
      sat_bit = any_ovf;
`else
      sat_bit = 1'b0;
`endif
      stim_q.push_back(beat(1'b0, 1'b1, 16'hF0F0));
      exp_q.push_back(beat(1'b0, 1'b1, {14'h3C3C, sat_bit, 1'b0}));
      applyStimulus("fullscale");

      stim_q.delete(); exp_q.delete();
      add_header();
      repeat (5) stim_q.push_back(beat(1'b0, 1'b0, 16'h4000));
      foreach (stim_q[i]) send_beat(stim_q[i], ok);
      @(negedge clk);
      in_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      checkOutput("midreset_outputs", {o_valid, o_sop, o_eop, o_data}, 19'h0);
      reset = 1'b0;
      build_impulse();
      applyStimulus("post_reset");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
